issue_responder: RTL and testbench
==================================

ISSUE_RESPONDER -- requirements
Module: issue_responder

Interface
REQ-001 SHALL have parameter SLOTS, default 4, giving reservation slots per unit class (power of two, 1..8).
REQ-002 SHALL have parameter NREGS, default 64, giving the architectural register count (6-bit index).
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 enable  input  1  fetch issue request, valid for one evaluation.
REQ-006 unit  input  3  class: 000 lw, 001 sw, 010 add, 011 mul, 100 mv, 101 halt.
REQ-007 reg1, reg2, reg3  input  6 each  dest/source register indices, per fetch encoding.
REQ-008 hasimm  input  1  second source is imm, not reg3 (mv: not reg2).
REQ-009 imm  input  32 signed  immediate, already sign-extended by fetch.
REQ-010 out  output  1  accept; combinational from current state and request inputs.
REQ-011 regread  input  1; regin  input  6  register status query.
REQ-012 regout  output  8  tag of pending producer, or 8'h7F when the value is ready.
REQ-013 regoutrf  output  32 signed  register file value, meaningful when regout==8'h7F.
REQ-014 cdb_valid  input  1; cdb_tag  input  8; cdb_value  input  32  completion broadcast.
REQ-015 iss_valid  output  1; iss_unit  output  3; iss_tag  output  8; iss_qj, iss_qk  output  8; iss_vj, iss_vk  output  32  registered issue packet to execution units.
REQ-016 halted  output  1  halt instruction accepted.

Function
REQ-017 Tag format SHALL be {1'b1, unit[2:0], 1'b0, slot[2:0]}; 8'h7F SHALL never be a tag.
REQ-018 out SHALL be 1 iff enable, !halted, unit<=101, and class has a free slot (halt always has room).
REQ-019 On accepted lw/add/mul/mv, SHALL allocate the lowest free slot and set status[reg1]=new tag at the edge.
REQ-020 On accepted sw, SHALL allocate a slot, treat reg1 as a source, and leave all status unchanged.
REQ-021 Sources: j=reg2 (mv: none), k=imm if hasimm else reg3 (mv non-imm: reg2); ready source gives q=8'h7F, v=value; pending gives q=tag, v=0.
REQ-022 iss_valid SHALL pulse for exactly one cycle after each accepted non-halt request, with packet from that edge.
REQ-023 Accepted halt SHALL set halted; out SHALL stay 0 until reset; no iss_valid.
REQ-024 cdb_valid SHALL free the slot named by cdb_tag and, for every register whose status equals cdb_tag, write cdb_value and set status 8'h7F.
REQ-025 Same-edge issue and CDB to one register: issue tag SHALL win; CDB value still written to the file.
REQ-026 Slot freed by CDB in the same cycle SHALL NOT be reusable until the next cycle (out uses pre-edge occupancy).
REQ-027 CDB with unknown or already-free tag SHALL be ignored without corrupting state.
REQ-028 regout/regoutrf SHALL be combinational from regin; when regread=0 they SHALL be 8'h7F and 0.
REQ-029 Register 0 SHALL read value 0, ready, and SHALL never be renamed or written.

Reset
REQ-030 On rst: all status 8'h7F, all registers 0, all slots free, halted=0, iss_valid=0, packet fields 0.
REQ-031 rst SHALL override a same-edge issue or CDB; out SHALL be 0 while rst is high.

Configuration
REQ-032 ISSUE_CDB_BYPASS_EN defined: a same-cycle CDB match SHALL forward cdb_value/8'h7F into regout/regoutrf and captured sources.
REQ-033 Not defined: query and capture SHALL see only pre-edge state; the pending tag is captured.

Structure
REQ-034 Shared package bourgeois_pkg SHALL hold WORD_SIZE, REG_SIZE, UNIT_SIZE, unit codes, READY_TAG=8'h7F and the tag layout.
REQ-035 Sub-module rename_table SHALL hold status and register file, with two read ports, query port, one rename and one CDB write.

Verification
REQ-036 Reset, regread regin=5 -> regout 8'h7F, regoutrf 0.
REQ-037 Issue add r3,r1,r2 -> out=1, next cycle iss_valid, iss_tag 8'hA0; query r3 -> 8'hA0.
REQ-038 Five back-to-back mul issues with SLOTS=4 -> fifth out=0; CDB 8'hB1 -> next-cycle mul accepted into slot 1.
REQ-039 CDB tag 8'hA0 value 42 -> r3 reads ready 42; bypass build shows 42 in the same cycle.
REQ-040 Issue halt -> halted=1; later add request -> out=0, no iss_valid.
REQ-041 rst asserted same edge as accepted lw -> status 8'h7F, no iss_valid.

Source files
------------

// File: rtl/bourgeois_pkg.sv
// Shared issue-stage types: word/register widths, unit class codes, tag layout and FSM states.
package bourgeois_pkg;
  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 6;
  localparam int UNIT_SIZE = 3;
  localparam int TAG_SIZE  = 8;
  localparam int NCLASS    = 5;

  typedef enum logic [UNIT_SIZE-1:0] {
    UNIT_LW   = 3'b000,
    UNIT_SW   = 3'b001,
    UNIT_ADD  = 3'b010,
    UNIT_MUL  = 3'b011,
    UNIT_MV   = 3'b100,
    UNIT_HALT = 3'b101
  } unit_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } issue_state_e;

  localparam logic [TAG_SIZE-1:0] READY_TAG = 8'h7F;

  typedef struct packed {
    logic [TAG_SIZE-1:0]         q;
    logic signed [WORD_SIZE-1:0] v;
  } operand_t;

  // Layout {1, unit, 0, slot}: bit 7 set keeps every tag distinct from READY_TAG.
  function automatic logic [TAG_SIZE-1:0] make_tag(input logic [UNIT_SIZE-1:0] u,
                                                   input logic [2:0] s);
    return {1'b1, u, 1'b0, s};
  endfunction
endpackage

// File: rtl/rename_table.sv
// Register status (pending producer tag) and register file: two operand read ports, one query
// port, one rename write and one CDB broadcast write. ISSUE_CDB_BYPASS_EN forwards same-cycle CDB.
module rename_table
  import bourgeois_pkg::*;
#(
  parameter int NREGS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_SIZE-1:0]         rda_idx,
  output operand_t                    rda,
  input  logic [REG_SIZE-1:0]         rdb_idx,
  output operand_t                    rdb,
  input  logic [REG_SIZE-1:0]         qry_idx,
  output operand_t                    qry,
  input  logic                        ren_en,
  input  logic [REG_SIZE-1:0]         ren_idx,
  input  logic [TAG_SIZE-1:0]         ren_tag,
  input  logic                        cdb_en,
  input  logic [TAG_SIZE-1:0]         cdb_tag,
  input  logic signed [WORD_SIZE-1:0] cdb_value
);
  logic [TAG_SIZE-1:0]         status [NREGS];
  logic signed [WORD_SIZE-1:0] rf     [NREGS];

  function automatic operand_t lookup(input logic [REG_SIZE-1:0] idx);
    operand_t o;
    o.q = status[idx];
    o.v = '0;
    if (idx == '0) begin
      o.q = READY_TAG;
    end else if (status[idx] == READY_TAG) begin
      o.v = rf[idx];
`ifdef ISSUE_CDB_BYPASS_EN
    end else if (cdb_en && status[idx] == cdb_tag) begin
      o.q = READY_TAG;
      o.v = cdb_value;
`endif
    end
    return o;
  endfunction

  always_comb begin
    rda = lookup(rda_idx);
    rdb = lookup(rdb_idx);
    qry = lookup(qry_idx);
  end

  // Rename is applied after the broadcast so a same-edge issue tag wins on status.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        status[i] <= READY_TAG;
        rf[i]     <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (cdb_en && status[i] == cdb_tag) begin
          rf[i]     <= cdb_value;
          status[i] <= READY_TAG;
        end
      end
      if (ren_en && ren_idx != '0) status[ren_idx] <= ren_tag;
    end
  end
endmodule

// File: rtl/issue_responder.sv
// Issue stage: reservation-slot allocation, register renaming and a registered issue packet.
// Optional macro ISSUE_CDB_BYPASS_EN forwards a same-cycle CDB result into queries and sources.
module issue_responder
  import bourgeois_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int NREGS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [UNIT_SIZE-1:0]        unit,
  input  logic [REG_SIZE-1:0]         reg1,
  input  logic [REG_SIZE-1:0]         reg2,
  input  logic [REG_SIZE-1:0]         reg3,
  input  logic                        hasimm,
  input  logic signed [WORD_SIZE-1:0] imm,
  output logic                        out,
  input  logic                        regread,
  input  logic [REG_SIZE-1:0]         regin,
  output logic [TAG_SIZE-1:0]         regout,
  output logic signed [WORD_SIZE-1:0] regoutrf,
  input  logic                        cdb_valid,
  input  logic [TAG_SIZE-1:0]         cdb_tag,
  input  logic [WORD_SIZE-1:0]        cdb_value,
  output logic                        iss_valid,
  output logic [UNIT_SIZE-1:0]        iss_unit,
  output logic [TAG_SIZE-1:0]         iss_tag,
  output logic [TAG_SIZE-1:0]         iss_qj,
  output logic [TAG_SIZE-1:0]         iss_qk,
  output logic signed [WORD_SIZE-1:0] iss_vj,
  output logic signed [WORD_SIZE-1:0] iss_vk,
  output logic                        halted
);
  issue_state_e                state, state_nxt;
  logic [SLOTS-1:0]            busy [NCLASS];
  logic [SLOTS-1:0]            cls_busy;
  logic [2:0]                  free_slot;
  logic [TAG_SIZE-1:0]         new_tag;
  logic                        accept, alloc, cdb_hit;
  logic [REG_SIZE-1:0]         rda_idx, rdb_idx;
  operand_t                    rda, rdb, qry, src_j, src_k;
  logic                        vld_p1;
  logic [UNIT_SIZE-1:0]        unit_p1;
  logic [TAG_SIZE-1:0]         tag_p1, qj_p1, qk_p1;
  logic signed [WORD_SIZE-1:0] vj_p1, vk_p1;

  always_comb begin
    cls_busy = '1;
    for (int c = 0; c < NCLASS; c++)
      if (unit == UNIT_SIZE'(c)) cls_busy = busy[c];
    free_slot = '0;
    for (int s = SLOTS - 1; s >= 0; s--)
      if (!cls_busy[s]) free_slot = 3'(s);
    new_tag = make_tag(unit, free_slot);
  end

  // Only a tag that names a currently occupied slot counts; anything else is ignored.
  always_comb begin
    cdb_hit = 1'b0;
    for (int c = 0; c < NCLASS; c++)
      for (int s = 0; s < SLOTS; s++)
        if (cdb_valid && busy[c][s] && cdb_tag == make_tag(UNIT_SIZE'(c), 3'(s))) cdb_hit = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    alloc     = 1'b0;
    case (state)
      ST_RUN: begin
        if (enable && !rst) begin
          if (unit == UNIT_HALT) begin
            accept    = 1'b1;
            state_nxt = ST_HALT;
          end else if (unit < UNIT_HALT && !(&cls_busy)) begin
            accept = 1'b1;
            alloc  = 1'b1;
          end
        end
      end
      ST_HALT: state_nxt = ST_HALT;
    endcase
  end

  assign out    = accept;
  assign halted = (state == ST_HALT);

  // Occupancy is judged pre-edge, so a slot freed by this cycle's CDB is not reallocated now.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCLASS; c++) busy[c] <= '0;
    end else begin
      for (int c = 0; c < NCLASS; c++)
        for (int s = 0; s < SLOTS; s++) begin
          if (cdb_hit && cdb_tag == make_tag(UNIT_SIZE'(c), 3'(s))) busy[c][s] <= 1'b0;
          if (alloc && unit == UNIT_SIZE'(c) && free_slot == 3'(s)) busy[c][s] <= 1'b1;
        end
    end
  end

  // sw carries reg1 (store data) on the j side; mv copies reg2 or imm through the k side.
  assign rda_idx = (unit == UNIT_SW) ? reg1 : reg2;
  assign rdb_idx = (unit == UNIT_MV) ? reg2 : reg3;

  always_comb begin
    src_j = rda;
    if (unit == UNIT_MV) begin
      src_j.q = READY_TAG;
      src_j.v = '0;
    end
    src_k = rdb;
    if (hasimm) begin
      src_k.q = READY_TAG;
      src_k.v = imm;
    end
  end

  rename_table #(.NREGS(NREGS)) u_rt (
    .clk       (clk),
    .rst       (rst),
    .rda_idx   (rda_idx),
    .rda       (rda),
    .rdb_idx   (rdb_idx),
    .rdb       (rdb),
    .qry_idx   (regin),
    .qry       (qry),
    .ren_en    (alloc && unit != UNIT_SW),
    .ren_idx   (reg1),
    .ren_tag   (new_tag),
    .cdb_en    (cdb_hit),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value)
  );

  assign regout   = regread ? qry.q : READY_TAG;
  assign regoutrf = regread ? qry.v : '0;

  // Issue stage boundary: packet captured at the accepting edge, valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      unit_p1 <= '0;
      tag_p1  <= '0;
      qj_p1   <= '0;
      qk_p1   <= '0;
      vj_p1   <= '0;
      vk_p1   <= '0;
    end else begin
      vld_p1 <= alloc;
      if (alloc) begin
        unit_p1 <= unit;
        tag_p1  <= new_tag;
        qj_p1   <= src_j.q;
        qk_p1   <= src_k.q;
        vj_p1   <= src_j.v;
        vk_p1   <= src_k.v;
      end
    end
  end

  assign iss_valid = vld_p1;
  assign iss_unit  = unit_p1;
  assign iss_tag   = tag_p1;
  assign iss_qj    = qj_p1;
  assign iss_qk    = qk_p1;
  assign iss_vj    = vj_p1;
  assign iss_vk    = vk_p1;
endmodule

// File: tb/tb_issue_responder.sv
// Bench for issue_responder: directed vector table plus randomized traffic against a reference model.
module tb_issue_responder;
  localparam int SLOTS = 4;
`ifdef ISSUE_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, hasimm, regread, cdb_valid, out, iss_valid, halted;
  logic [2:0] unit, iss_unit;
  logic [5:0] reg1, reg2, reg3, regin;
  logic signed [31:0] imm, regoutrf, iss_vj, iss_vk;
  logic [31:0] cdb_value;
  logic [7:0] cdb_tag, regout, iss_tag, iss_qj, iss_qk;
  int checks = 0;
  int failures = 0;

  issue_responder #(.SLOTS(SLOTS), .NREGS(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .unit(unit), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .hasimm(hasimm), .imm(imm), .out(out), .regread(regread), .regin(regin), .regout(regout),
    .regoutrf(regoutrf), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_unit(iss_unit), .iss_tag(iss_tag), .iss_qj(iss_qj),
    .iss_qk(iss_qk), .iss_vj(iss_vj), .iss_vk(iss_vk), .halted(halted)
  );

  typedef struct packed {
    logic        rst, en;
    logic [2:0]  unit;
    logic [5:0]  r1, r2, r3;
    logic        hi;
    logic [31:0] imm;
    logic        rr;
    logic [5:0]  rin;
    logic        cv;
    logic [7:0]  ct;
    logic [31:0] cval;
    logic        x_out;
    logic [7:0]  x_rout;
    logic [31:0] x_rrf;
    logic        x_iv;
    logic [7:0]  x_itag;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  // Reference state: slot occupancy per class, register status and values, halt flag.
  bit          m_busy [5][8];
  logic [7:0]  m_stat [64];
  logic [31:0] m_rf   [64];
  bit          m_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_stat[i] = 8'h7F;
      m_rf[i]   = '0;
    end
    for (int c = 0; c < 5; c++)
      for (int s = 0; s < 8; s++) m_busy[c][s] = 1'b0;
    m_halt = 1'b0;
  endfunction

  function automatic bit m_hit();
    int c, s;
    c = int'(cdb_tag[6:4]);
    s = int'(cdb_tag[2:0]);
    if (!cdb_valid || !cdb_tag[7] || cdb_tag[3] || c > 4 || s >= SLOTS) return 1'b0;
    return m_busy[c][s];
  endfunction

  function automatic void m_src(input logic [5:0] idx, output logic [7:0] q, output logic [31:0] v);
    q = 8'h7F;
    v = '0;
    if (idx == 6'd0) return;
    if (m_stat[idx] == 8'h7F) v = m_rf[idx];
    else if (BYP && m_hit() && m_stat[idx] == cdb_tag) v = cdb_value;
    else q = m_stat[idx];
  endfunction

  function automatic int m_free(input logic [2:0] u);
    if (u > 3'd4) return -1;
    for (int s = 0; s < SLOTS; s++) if (!m_busy[u][s]) return s;
    return -1;
  endfunction

  // Drive one cycle at the falling edge, check combinational outputs, then the registered packet.
  task automatic step(input vec_t v, input bit use_x, input string nm);
    bit exp_out, exp_iv, hit;
    int fs;
    logic [7:0] eq, ejq, ekq, etag;
    logic [31:0] ev, ejv, ekv;
    rst = v.rst; enable = v.en; unit = v.unit; reg1 = v.r1; reg2 = v.r2; reg3 = v.r3;
    hasimm = v.hi; imm = v.imm; regread = v.rr; regin = v.rin;
    cdb_valid = v.cv; cdb_tag = v.ct; cdb_value = v.cval;
    #1;
    fs = m_free(unit);
    exp_out = enable && !rst && !m_halt && (unit == 3'd5 || fs >= 0);
    exp_iv  = exp_out && unit != 3'd5;
    m_src(regin, eq, ev);
    if (!regread) begin eq = 8'h7F; ev = '0; end
    if (use_x) begin
      chk({nm, "_out"}, 32'(out), 32'(v.x_out));
      chk({nm, "_regout"}, 32'(regout), 32'(v.x_rout));
      chk({nm, "_regoutrf"}, regoutrf, v.x_rrf);
    end
    chk({nm, "_m_out"}, 32'(out), 32'(exp_out));
    chk({nm, "_m_regout"}, 32'(regout), 32'(eq));
    chk({nm, "_m_regoutrf"}, regoutrf, ev);
    if (unit == 3'd4) begin ejq = 8'h7F; ejv = '0; end
    else m_src((unit == 3'd1) ? reg1 : reg2, ejq, ejv);
    if (hasimm) begin ekq = 8'h7F; ekv = imm; end
    else m_src((unit == 3'd4) ? reg2 : reg3, ekq, ekv);
    etag = {1'b1, unit, 1'b0, 3'(fs)};
    hit = m_hit();
    @(posedge clk);
    if (rst) m_reset();
    else begin
      if (hit) begin
        m_busy[cdb_tag[6:4]][cdb_tag[2:0]] = 1'b0;
        for (int i = 1; i < 64; i++)
          if (m_stat[i] == cdb_tag) begin m_rf[i] = cdb_value; m_stat[i] = 8'h7F; end
      end
      if (exp_iv) begin
        m_busy[unit][fs] = 1'b1;
        if (unit != 3'd1 && reg1 != 6'd0) m_stat[reg1] = etag;
      end
      if (exp_out && unit == 3'd5) m_halt = 1'b1;
    end
    #1;
    if (use_x) begin
      chk({nm, "_iss_valid"}, 32'(iss_valid), 32'(v.x_iv));
      if (v.x_iv) chk({nm, "_iss_tag"}, 32'(iss_tag), 32'(v.x_itag));
    end
    chk({nm, "_m_iss_valid"}, 32'(iss_valid), 32'(exp_iv));
    chk({nm, "_m_halted"}, 32'(halted), 32'(m_halt));
    if (exp_iv) begin
      chk({nm, "_m_iss_unit"}, 32'(iss_unit), 32'(unit));
      chk({nm, "_m_iss_tag"}, 32'(iss_tag), 32'(etag));
      chk({nm, "_m_iss_qj"}, 32'(iss_qj), 32'(ejq));
      chk({nm, "_m_iss_vj"}, iss_vj, ejv);
      chk({nm, "_m_iss_qk"}, 32'(iss_qk), 32'(ekq));
      chk({nm, "_m_iss_vk"}, iss_vk, ekv);
    end
    if (rst) begin
      chk({nm, "_rst_iss_tag"}, 32'(iss_tag), 32'd0);
      chk({nm, "_rst_iss_vk"}, iss_vk, 32'd0);
    end
    @(negedge clk);
  endtask

  task automatic setreq(input int i, input logic [2:0] u, input logic [5:0] a, b, c);
    tbl[i].en = 1'b1; tbl[i].unit = u; tbl[i].r1 = a; tbl[i].r2 = b; tbl[i].r3 = c;
  endtask
  task automatic setq(input int i, input logic rr, input logic [5:0] rin,
                      input logic [7:0] xr, input logic [31:0] xv);
    tbl[i].rr = rr; tbl[i].rin = rin; tbl[i].x_rout = xr; tbl[i].x_rrf = xv;
  endtask
  task automatic setx(input int i, input logic xo, input logic xiv, input logic [7:0] xt);
    tbl[i].x_out = xo; tbl[i].x_iv = xiv; tbl[i].x_itag = xt;
  endtask
  task automatic setcdb(input int i, input logic [7:0] t, input logic [31:0] val);
    tbl[i].cv = 1'b1; tbl[i].ct = t; tbl[i].cval = val;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    logic [7:0] btags [$];
    int u;

    for (int i = 0; i < NV; i++) tbl[i] = '0;
    tbl[0].rst = 1'b1;  setreq(0, 3'd0, 6'd4, 6'd1, 6'd2); setq(0, 1'b1, 6'd5, 8'h7F, 0);
    setx(0, 1'b0, 1'b0, 8'h00);
    setq(1, 1'b1, 6'd4, 8'h7F, 0);
    setreq(2, 3'd2, 6'd3, 6'd1, 6'd2); setq(2, 1'b1, 6'd3, 8'h7F, 0); setx(2, 1'b1, 1'b1, 8'hA0);
    setq(3, 1'b1, 6'd3, 8'hA0, 0);
    for (int i = 4; i < 8; i++) begin
      setreq(i, 3'd3, 6'(i), 6'd1, 6'd2); setq(i, 1'b1, 6'd3, 8'hA0, 0);
      setx(i, 1'b1, 1'b1, 8'hB0 + 8'(i - 4));
    end
    setreq(8, 3'd3, 6'd8, 6'd1, 6'd2); setcdb(8, 8'hB1, 32'd7);
    setq(8, 1'b1, 6'd5, BYP ? 8'h7F : 8'hB1, BYP ? 32'd7 : 32'd0);
    setreq(9, 3'd3, 6'd8, 6'd1, 6'd2); setq(9, 1'b1, 6'd5, 8'h7F, 32'd7); setx(9, 1'b1, 1'b1, 8'hB1);
    setcdb(10, 8'hA0, 32'd42); setq(10, 1'b1, 6'd3, BYP ? 8'h7F : 8'hA0, BYP ? 32'd42 : 32'd0);
    setcdb(11, 8'h7F, 32'd99); setq(11, 1'b1, 6'd3, 8'h7F, 32'd42);
    setreq(12, 3'd5, 6'd0, 6'd0, 6'd0); setq(12, 1'b0, 6'd4, 8'h7F, 0); setx(12, 1'b1, 1'b0, 8'h00);
    setreq(13, 3'd2, 6'd3, 6'd1, 6'd2); setq(13, 1'b1, 6'd0, 8'h7F, 0);
    tbl[14].rst = 1'b1; setreq(14, 3'd0, 6'd9, 6'd1, 6'd2); setq(14, 1'b1, 6'd8, 8'hB1, 0);
    setq(15, 1'b1, 6'd8, 8'h7F, 0);

    rst = 1'b1; enable = 1'b0; unit = '0; reg1 = '0; reg2 = '0; reg3 = '0; hasimm = 1'b0;
    imm = '0; regread = 1'b0; regin = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    m_reset();
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) step(tbl[i], 1'b1, $sformatf("row%0d", i));

    for (int n = 0; n < 600; n++) begin
      v = '0;
      v.rst = ($urandom_range(0, 39) == 0);
      v.en  = ($urandom_range(0, 9) < 7);
      u = $urandom_range(0, 79);
      if (u == 0) v.unit = 3'd5;
      else if (u == 1) v.unit = 3'($urandom_range(6, 7));
      else v.unit = 3'(u % 5);
      v.r1 = 6'($urandom_range(0, 7));
      v.r2 = 6'($urandom_range(0, 7));
      v.r3 = 6'($urandom_range(0, 7));
      v.hi = 1'($urandom_range(0, 1));
      v.imm = $urandom;
      v.rr = ($urandom_range(0, 4) != 0);
      v.rin = 6'($urandom_range(0, 7));
      v.cv = 1'($urandom_range(0, 1));
      btags.delete();
      for (int c = 0; c < 5; c++)
        for (int s = 0; s < SLOTS; s++)
          if (m_busy[c][s]) btags.push_back({1'b1, 3'(c), 1'b0, 3'(s)});
      if (btags.size() > 0 && $urandom_range(0, 3) != 0)
        v.ct = btags[$urandom_range(0, btags.size() - 1)];
      else
        v.ct = 8'($urandom);
      v.cval = $urandom;
      step(v, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
